pmt_count_packer: RTL

- Downstream stage of the per-bin count combiner.
- Samples the combiner's 16-bit result and its two-byte flag at each time-bin boundary, and buffers the samples in a small FIFO.
- Serialises each sample into 1 or 2 bytes on a valid/ready byte stream that feeds the UART/USB transmitter.
- Absorbs transmitter back-pressure; counts bins dropped when the buffer is full.

---
 rtl/pmt_count_packer_if.sv | 20 ++
 rtl/pmt_count_packer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/pmt_count_packer_if.sv
// Byte-stream bundle between the count combiner, the packer and the transmitter.
// The packer takes the master modport: it sources the tx byte stream.
interface pmt_count_packer_if;
  logic        bin_done;
  logic [15:0] sumout;
  logic        two_bytes;
  logic        tx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;

  modport master (
    input  bin_done, sumout, two_bytes, tx_ready,
    output tx_valid, tx_data
  );

  modport slave (
    output bin_done, sumout, two_bytes, tx_ready,
    input  tx_valid, tx_data
  );
endinterface

// File: rtl/pmt_count_packer.sv
// Buffers per-bin {two_bytes, sumout} samples and serialises each one as a
// low byte, optionally followed by its high byte, on a valid/ready stream.
module pmt_count_packer #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LEVEL_W    = 5
) (
  input  logic               clock,
  input  logic               reset_n,
  pmt_count_packer_if.master bus,
  output logic [LEVEL_W-1:0] fifo_level,
  output logic [7:0]         drop_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH
  } state_t;

  state_t state, state_n;

  logic [16:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [16:0]   head;

  logic          tx_valid_r;
  logic          valid_n;
  logic [7:0]    tx_data_r;
  logic          hi_flag;
  logic [7:0]    hi_byte;

  logic          full;
  logic          empty;
  logic          wr_en;
  logic          drop;
  logic          transfer;
  logic          pop;
  logic          load_low;
  logic          load_high;

  assign full     = (fifo_level == LEVEL_W'(FIFO_DEPTH));
  assign empty    = (fifo_level == '0);
  // A full FIFO drops the sample even if a pop frees a slot on the same edge.
  assign wr_en    = bus.bin_done & ~full;
  assign drop     = bus.bin_done & full;
  assign transfer = tx_valid_r & bus.tx_ready;
  assign head     = mem[rd_ptr];

  assign bus.tx_valid = tx_valid_r;
  assign bus.tx_data  = tx_data_r;

  always_ff @(posedge clock) begin
    if (reset_n && wr_en) begin
      mem[wr_ptr] <= {bus.two_bytes, bus.sumout};
    end
  end

  always_comb begin
    state_n   = state;
    valid_n   = tx_valid_r;
    pop       = 1'b0;
    load_low  = 1'b0;
    load_high = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          load_low = 1'b1;
          valid_n  = 1'b1;
          state_n  = LOW;
        end
      end
      LOW: begin
        if (transfer) begin
          if (hi_flag) begin
            load_high = 1'b1;
            state_n   = HIGH;
          end else if (!empty) begin
            pop      = 1'b1;
            load_low = 1'b1;
          end else begin
            valid_n = 1'b0;
            state_n = IDLE;
          end
        end
      end
      HIGH: begin
        if (transfer) begin
          if (!empty) begin
            pop      = 1'b1;
            load_low = 1'b1;
            state_n  = LOW;
          end else begin
            valid_n = 1'b0;
            state_n = IDLE;
          end
        end
      end
      default: begin
        valid_n = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      drop_count <= '0;
      tx_valid_r <= 1'b0;
      tx_data_r  <= '0;
      hi_flag    <= 1'b0;
      hi_byte    <= '0;
    end else begin
      state      <= state_n;
      tx_valid_r <= valid_n;

      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end

      case ({wr_en, pop})
        2'b10:   fifo_level <= fifo_level + LEVEL_W'(1);
        2'b01:   fifo_level <= fifo_level - LEVEL_W'(1);
        default: fifo_level <= fifo_level;
      endcase

      if (drop && (drop_count != '1)) begin
        drop_count <= drop_count + 8'd1;
      end

      // The high half of the entry is parked here so the FIFO slot can be
      // released at the same edge the low byte is presented.
      if (load_low) begin
        tx_data_r <= head[7:0];
        hi_flag   <= head[16];
        hi_byte   <= head[15:8];
      end else if (load_high) begin
        tx_data_r <= hi_byte;
      end
    end
  end

endmodule
